// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the memory responder: FSM states, response codes, bus widths.
package ahb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DATA,
        ERR1,
        ERR2
    } ahb_state_e;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam int         AHB_DATA_W    = 32;

endpackage

// File: rtl/ahb_slave_mem_array.sv
// DEPTH x 32 storage for the AHB memory slave: one synchronous write port, one asynchronous read port.
module ahb_slave_mem_array
    import ahb_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [AHB_DATA_W-1:0]    wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [AHB_DATA_W-1:0]    rdata_o
);

    logic [AHB_DATA_W-1:0] mem_q [DEPTH];

    // Contents survive bus reset on purpose; there is no reset port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB single-transfer responder backed by a word-addressed memory with a programmable stall.
// Define AHB_SLAVE_MEM_ERR_EN to answer out-of-range addresses with a two-cycle ERROR response.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter logic [3:0] SLAVE_ID    = 4'b0001,
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic [3:0]            sel,
    input  logic [31:0]           haddr,
    input  logic                  hwrite,
    input  logic [2:0]            hburst,
    input  logic                  hready,
    input  logic [AHB_DATA_W-1:0] hwdata,
    output logic [AHB_DATA_W-1:0] hrdata,
    output logic                  hreadyout,
    output logic                  hresp
);

    localparam int AW = $clog2(DEPTH);

    ahb_state_e            state_q;
    logic [3:0]            cnt_q;
    logic                  wr_q;
    logic                  err_q;
    logic [AW-1:0]         idx_q;
    logic [AHB_DATA_W-1:0] hrdata_q;
    logic                  hreadyout_q;
    logic                  hresp_q;

    logic                  accept;
    logic                  addr_err;
    logic                  mem_we;
    logic [AW-1:0]         rd_idx;
    logic [AHB_DATA_W-1:0] mem_rdata;
    logic [AHB_DATA_W-1:0] rd_data_d;
    logic                  unused_bits;

    assign accept = (sel == SLAVE_ID) && hready && hreadyout_q;

`ifdef AHB_SLAVE_MEM_ERR_EN
    assign addr_err = |haddr[31:AW+2];
`else
    assign addr_err = 1'b0;
`endif

    // Every burst type is served as SINGLE; the byte-lane bits carry no meaning for word access.
    assign unused_bits = ^{hburst, haddr[1:0], haddr[31:AW+2]};

    // The write commits on the edge that ends DATA.
    assign mem_we = (state_q == DATA) && wr_q;

    // Entering DATA from WAIT uses the latched index; a zero-wait accept uses the live address.
    assign rd_idx    = (state_q == WAIT) ? idx_q : haddr[AW+1:2];
    assign rd_data_d = (mem_we && (idx_q == rd_idx)) ? hwdata : mem_rdata;

    ahb_slave_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (hclk),
        .we_i    (mem_we),
        .waddr_i (idx_q),
        .wdata_i (hwdata),
        .raddr_i (rd_idx),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            case (state_q)
                IDLE, DATA, ERR2: begin
                    if (accept) begin
                        wr_q  <= hwrite;
                        idx_q <= haddr[AW+1:2];
                        err_q <= addr_err;
                        if (WAIT_STATES > 0) begin
                            state_q     <= WAIT;
                            cnt_q       <= 4'(WAIT_STATES - 1);
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_OKAY;
                        end else if (addr_err) begin
                            state_q     <= ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_ERROR;
                        end else begin
                            state_q     <= DATA;
                            hrdata_q    <= rd_data_d;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= HRESP_OKAY;
                        end
                    end else begin
                        state_q     <= IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (err_q) begin
                        state_q <= ERR1;
                        hresp_q <= HRESP_ERROR;
                    end else begin
                        state_q     <= DATA;
                        hrdata_q    <= rd_data_d;
                        hreadyout_q <= 1'b1;
                    end
                end
                ERR1: begin
                    state_q     <= ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    state_q     <= IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign hrdata    = hrdata_q;
    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two slaves (zero and three wait states) on one bus, randomized transfers
// checked cycle by cycle against a transfer-level memory model.
module tb_ahb_slave_mem;

    localparam int         NS    = 2;
    localparam logic [3:0] ID0   = 4'b0001;
    localparam logic [3:0] ID1   = 4'b0010;
    localparam int         WS0   = 0;
    localparam int         WS1   = 3;
    localparam int         WORDS = 64;
`ifdef AHB_SLAVE_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int          s;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
    } xfer_t;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [3:0]  sel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hburst;
    logic        hready;
    logic [31:0] hwdata;
    logic [31:0] hrdata_w    [NS];
    logic        hreadyout_w [NS];
    logic        hresp_w     [NS];

    logic [31:0] mem_m  [NS][WORDS];
    logic [31:0] exp_rd [NS];
    xfer_t       pend[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 hclk = ~hclk;

    ahb_slave_mem #(.SLAVE_ID(ID0), .DEPTH(WORDS), .WAIT_STATES(WS0)) u_slv0 (
        .hclk(hclk), .hresetn(hresetn), .sel(sel), .haddr(haddr), .hwrite(hwrite),
        .hburst(hburst), .hready(hready), .hwdata(hwdata),
        .hrdata(hrdata_w[0]), .hreadyout(hreadyout_w[0]), .hresp(hresp_w[0])
    );

    ahb_slave_mem #(.SLAVE_ID(ID1), .DEPTH(WORDS), .WAIT_STATES(WS1)) u_slv1 (
        .hclk(hclk), .hresetn(hresetn), .sel(sel), .haddr(haddr), .hwrite(hwrite),
        .hburst(hburst), .hready(hready), .hwdata(hwdata),
        .hrdata(hrdata_w[1]), .hreadyout(hreadyout_w[1]), .hresp(hresp_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int ws_of(input int s);
        return (s == 0) ? WS0 : WS1;
    endfunction

    function automatic logic [3:0] id_of(input int s);
        return (s == 0) ? ID0 : ID1;
    endfunction

    function automatic bit addr_err(input logic [31:0] a);
        return ERR_EN && ((a / (WORDS * 4)) != 0);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % WORDS);
    endfunction

    task automatic push(input int s, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        xfer_t t;
        t.s = s; t.wr = wr; t.addr = addr; t.wd = wd;
        pend.push_back(t);
    endtask

    task automatic drive_addr(input xfer_t t);
        chk("addr_ready", 32'(hreadyout_w[t.s]), 32'd1);
        sel    = id_of(t.s);
        haddr  = t.addr;
        hwrite = t.wr;
        hready = 1'b1;
        hburst = 3'($urandom);
    endtask

    // Bus noise while slave s is busy: only s (or nobody) is selected, so only s could misbehave.
    task automatic drive_junk(input int s);
        sel    = $urandom_range(0, 1) ? id_of(s) : 4'h0;
        hready = 1'($urandom);
        haddr  = $urandom;
        hwrite = 1'($urandom);
        hburst = 3'($urandom);
        hwdata = $urandom;
    endtask

    task automatic drive_idle();
        case ($urandom_range(0, 3))
            0:       sel = ID0;
            1:       sel = ID1;
            2:       sel = 4'b0100;
            default: sel = 4'h0;
        endcase
        hready = (sel == ID0 || sel == ID1) ? 1'b0 : 1'($urandom);
        haddr  = $urandom;
        hwrite = 1'($urandom);
        hburst = 3'($urandom);
        hwdata = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            drive_idle();
            @(negedge hclk);
            for (int s = 0; s < NS; s++) begin
                chk("idle_ready", 32'(hreadyout_w[s]), 32'd1);
                chk("idle_resp", 32'(hresp_w[s]), 32'd0);
                chk("idle_rdata", hrdata_w[s], exp_rd[s]);
            end
        end
    endtask

    // Runs the queued transfers back to back; each next address phase overlaps the previous completion.
    task automatic run_pending();
        xfer_t t;
        int    idx;
        bit    err;
        int    last_s;
        drive_addr(pend[0]);
        for (int i = 0; i < pend.size(); i++) begin
            t   = pend[i];
            idx = word_of(t.addr);
            err = addr_err(t.addr);
            @(negedge hclk);
            for (int w = 0; w < ws_of(t.s); w++) begin
                chk("wait_ready", 32'(hreadyout_w[t.s]), 32'd0);
                chk("wait_resp", 32'(hresp_w[t.s]), 32'd0);
                chk("wait_rdata", hrdata_w[t.s], exp_rd[t.s]);
                drive_junk(t.s);
                @(negedge hclk);
            end
            if (err) begin
                chk("err1_ready", 32'(hreadyout_w[t.s]), 32'd0);
                chk("err1_resp", 32'(hresp_w[t.s]), 32'd1);
                chk("err1_rdata", hrdata_w[t.s], exp_rd[t.s]);
                drive_junk(t.s);
                @(negedge hclk);
                chk("err2_ready", 32'(hreadyout_w[t.s]), 32'd1);
                chk("err2_resp", 32'(hresp_w[t.s]), 32'd1);
                chk("err2_rdata", hrdata_w[t.s], exp_rd[t.s]);
            end else begin
                exp_rd[t.s] = mem_m[t.s][idx];
                chk("data_ready", 32'(hreadyout_w[t.s]), 32'd1);
                chk("data_resp", 32'(hresp_w[t.s]), 32'd0);
                chk("data_rdata", hrdata_w[t.s], exp_rd[t.s]);
            end
            if (i + 1 < pend.size()) drive_addr(pend[i+1]);
            else                     drive_idle();
            hwdata = t.wd;
            if (t.wr && !err) mem_m[t.s][idx] = t.wd;
        end
        last_s = pend[pend.size()-1].s;
        pend.delete();
        @(negedge hclk);
        chk("end_ready", 32'(hreadyout_w[last_s]), 32'd1);
        chk("end_resp", 32'(hresp_w[last_s]), 32'd0);
        chk("end_rdata", hrdata_w[last_s], exp_rd[last_s]);
    endtask

    initial begin
        hresetn = 1'b0;
        sel = 4'h0; haddr = '0; hwrite = 1'b0; hburst = '0; hready = 1'b0; hwdata = '0;
        repeat (2) @(negedge hclk);
        for (int s = 0; s < NS; s++) begin
            chk("rst_ready", 32'(hreadyout_w[s]), 32'd1);
            chk("rst_resp", 32'(hresp_w[s]), 32'd0);
            chk("rst_rdata", hrdata_w[s], 32'd0);
            exp_rd[s] = '0;
        end
        hresetn = 1'b1;
        idle_cycles(2);

        // Give every word a known value; memory is not cleared by reset.
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < WORDS; w++)
                push(s, 1'b1, 32'(w * 4), $urandom);
        run_pending();

        push(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        run_pending();
        idle_cycles(1);
        push(0, 1'b0, 32'h10, 32'h0);
        run_pending();
        push(1, 1'b0, 32'h04, 32'h0);
        run_pending();
        push(0, 1'b1, 32'h20, 32'h1111_2222);
        push(0, 1'b0, 32'h20, 32'h0);
        push(1, 1'b1, 32'h20, 32'h3333_4444);
        push(1, 1'b0, 32'h20, 32'h0);
        run_pending();

        // No slave owns sel=4'b0100: nothing may be written anywhere.
        sel = 4'b0100; hwrite = 1'b1; haddr = 32'h0; hready = 1'b1; hwdata = 32'hBADC_0FFE;
        @(negedge hclk);
        for (int s = 0; s < NS; s++) begin
            chk("nosel_ready", 32'(hreadyout_w[s]), 32'd1);
            chk("nosel_rdata", hrdata_w[s], exp_rd[s]);
        end
        sel = 4'h0;
        @(negedge hclk);
        push(0, 1'b0, 32'h0, 32'h0);
        push(1, 1'b0, 32'h0, 32'h0);
        run_pending();

        // Upper address bits: ERROR when enabled, otherwise the index wraps.
        push(0, 1'b0, 32'h400, 32'h0);
        push(0, 1'b1, 32'h404, 32'hCAFE_0001);
        push(0, 1'b0, 32'h004, 32'h0);
        push(1, 1'b0, 32'h400, 32'h0);
        push(1, 1'b1, 32'h8000_0008, 32'hCAFE_0002);
        push(1, 1'b0, 32'h008, 32'h0);
        run_pending();

        for (int b = 0; b < 40; b++) begin
            int n;
            logic [31:0] a;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                a = 32'($urandom_range(0, WORDS - 1) * 4);
                if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(8, 31));
                push($urandom_range(0, NS - 1), 1'($urandom), a, $urandom);
            end
            run_pending();
            idle_cycles($urandom_range(0, 3));
        end

        // Reset in the middle of a stalled write: nothing is written, outputs snap back at once.
        push(1, 1'b1, 32'h40, 32'h5A5A_A5A5);
        drive_addr(pend[0]);
        pend.delete();
        @(negedge hclk);
        chk("rstmid_wait", 32'(hreadyout_w[1]), 32'd0);
        hwdata = 32'h5A5A_A5A5;
        #2 hresetn = 1'b0;
        #1;
        for (int s = 0; s < NS; s++) begin
            chk("rstmid_ready", 32'(hreadyout_w[s]), 32'd1);
            chk("rstmid_resp", 32'(hresp_w[s]), 32'd0);
            chk("rstmid_rdata", hrdata_w[s], 32'd0);
            exp_rd[s] = '0;
        end
        @(negedge hclk);
        hresetn = 1'b1;
        sel = 4'h0; hready = 1'b0;
        repeat (4) @(negedge hclk);
        idle_cycles(1);
        push(1, 1'b0, 32'h40, 32'h0);
        push(0, 1'b0, 32'h40, 32'h0);
        run_pending();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
